// File: rtl/adc_capture_pkg.sv
// Shared state encoding, default parameters and frame-length helper for the
// serial ADC capture engine.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_QUIET = 2'd1,
        ST_SETUP = 2'd2,
        ST_SHIFT = 2'd3
    } state_t;

    localparam int DEF_NUM_CH       = 2;
    localparam int DEF_DATA_W       = 12;
    localparam int DEF_LEAD_BITS    = 2;
    localparam int DEF_CLK_DIV      = 1;
    localparam int DEF_QUIET_CYCLES = 6;
    localparam int DEF_AVG_LOG2     = 2;

    // Main_CLK cycles from one QUIET entry to the next in continuous mode.
    function automatic int frame_cycles(input int quiet, input int div,
                                        input int lead, input int width);
        return quiet + div + 2 * div * (lead + width);
    endfunction

endpackage

// File: rtl/adc_shift_channel.sv
// One serial data lane: shift register plus output word register.
// With ADC_CAPTURE_AVG_EN defined, also a group accumulator (mean of 2^AVG_LOG2 frames).
module adc_shift_channel
    import adc_capture_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
`ifdef ADC_CAPTURE_AVG_EN
    ,
    parameter int AVG_LOG2 = DEF_AVG_LOG2
`endif
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              shift_en_i,
    input  logic              load_i,
`ifdef ADC_CAPTURE_AVG_EN
    input  logic              group_last_i,
    input  logic              discard_i,
`endif
    input  logic              data_i,
    output logic [DATA_W-1:0] word_o
);

    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] word_q;

    // Leading zero bits fall off the top; only the last DATA_W bits survive.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else if (shift_en_i) begin
            sr_q <= {sr_q[DATA_W-2:0], data_i};
        end
    end

`ifdef ADC_CAPTURE_AVG_EN
    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] avg;

    assign sum = acc_q + ACC_W'(sr_q);
    assign avg = DATA_W'(sum >> AVG_LOG2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            word_q <= '0;
        end else if (load_i) begin
            if (group_last_i) begin
                word_q <= avg;
                acc_q  <= '0;
            end else if (discard_i) begin
                acc_q <= '0;
            end else begin
                acc_q <= sum;
            end
        end
    end
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
        end else if (load_i) begin
            word_q <= sr_q;
        end
    end
`endif

    assign word_o = word_q;

endmodule

// File: rtl/adc_serial_capture.sv
// Capture engine for multi-lane SAR ADCs: drives CS/SCLK from Main_CLK and
// deserialises NUM_CH lanes. Optional frame averaging via ADC_CAPTURE_AVG_EN.
module adc_serial_capture
    import adc_capture_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int LEAD_BITS    = DEF_LEAD_BITS,
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int QUIET_CYCLES = DEF_QUIET_CYCLES,
    parameter int AVG_LOG2     = DEF_AVG_LOG2
) (
    input  logic                     Main_CLK,
    input  logic                     Reset,
    input  logic                     Enable,
    input  logic [NUM_CH-1:0]        Data_In,
    output logic                     CS,
    output logic                     SCLK,
    output logic [NUM_CH*DATA_W-1:0] Data_Out,
    output logic                     Data_Valid,
    output logic                     Busy
);

    localparam int NBITS   = LEAD_BITS + DATA_W;
    localparam int CNT_MAX = (QUIET_CYCLES > CLK_DIV) ? QUIET_CYCLES : CLK_DIV;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BIT_W   = (NBITS > 1) ? $clog2(NBITS) : 1;

    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NBITS - 1);

    // Illegal configurations elaborate this empty marker block.
    if (NUM_CH < 1 || CLK_DIV < 1 || QUIET_CYCLES < 1 || AVG_LOG2 < 0) begin : g_bad_cfg
    end

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              cs_q, cs_d;
    logic              sclk_q, sclk_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              shift_en;
    logic              load;

    always_ff @(posedge Main_CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    // Outputs are computed for the next state so pins change on the transition edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        cs_d     = cs_q;
        sclk_d   = sclk_q;
        busy_d   = busy_q;
        shift_en = 1'b0;
        load     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cs_d   = 1'b1;
                sclk_d = 1'b1;
                cnt_d  = '0;
                bit_d  = '0;
                busy_d = Enable;
                if (Enable) begin
                    state_d = ST_QUIET;
                end
            end
            ST_QUIET: begin
                if (cnt_q == QUIET_LAST) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    cs_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (cnt_q != DIV_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d   = 1'b1;
                        shift_en = 1'b1;
                    end else if (bit_q != BIT_LAST) begin
                        sclk_d = 1'b0;
                        bit_d  = bit_q + BIT_W'(1);
                    end else begin
                        load    = 1'b1;
                        cs_d    = 1'b1;
                        sclk_d  = 1'b1;
                        bit_d   = '0;
                        busy_d  = Enable;
                        state_d = Enable ? ST_QUIET : ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef ADC_CAPTURE_AVG_EN
    localparam int               FRM_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'((1 << AVG_LOG2) - 1);

    logic [FRM_W-1:0] frm_q, frm_d;
    logic             group_last;

    assign group_last = (frm_q == FRM_LAST);
    assign valid_d    = load & group_last;

    // A partial group is dropped when the frame ends with Enable low.
    always_comb begin
        frm_d = frm_q;
        if (load) begin
            frm_d = (group_last || !Enable) ? '0 : frm_q + FRM_W'(1);
        end
    end

    always_ff @(posedge Main_CLK or negedge Reset) begin
        if (!Reset) begin
            frm_q <= '0;
        end else begin
            frm_q <= frm_d;
        end
    end
`else
    assign valid_d = load;
`endif

    genvar gi;
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
        adc_shift_channel #(
            .DATA_W       (DATA_W)
`ifdef ADC_CAPTURE_AVG_EN
            ,
            .AVG_LOG2     (AVG_LOG2)
`endif
        ) u_ch (
            .clk_i        (Main_CLK),
            .rst_ni       (Reset),
            .shift_en_i   (shift_en),
            .load_i       (load),
`ifdef ADC_CAPTURE_AVG_EN
            .group_last_i (group_last),
            .discard_i    (!Enable),
`endif
            .data_i       (Data_In[gi]),
            .word_o       (Data_Out[gi*DATA_W +: DATA_W])
        );
    end

    assign CS         = cs_q;
    assign SCLK       = sclk_q;
    assign Data_Valid = valid_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_adc_serial_capture.sv
// Directed bench for adc_serial_capture: three configurations driven by a
// behavioural ADC serialiser; averaging checks run when ADC_CAPTURE_AVG_EN is set.
`timescale 1ns/1ps
module tb_adc_serial_capture;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_a  = 1'b0;
    logic        en_b  = 1'b0;
    logic        en_c  = 1'b0;
    logic [3:0]  din [3];
    logic        cs_v [3];
    logic        sclk_v [3];
    logic        valid_v [3];
    logic        busy_v [3];
    logic [23:0] dout_a;
    logic [23:0] dout_b;
    logic [55:0] dout_c;

    int n_checks = 0;
    int n_fail   = 0;
    int sel      = 0;

    // pat[dut][frame mod 4][channel], each word already includes its lead zeros
    logic [13:0] pat  [3][4][4];
    logic [13:0] strm [3][4];
    int          frm  [3];
    int          idx  [3];
    logic        pcs  [3];
    logic        psclk [3];

    logic        m_cs, m_sclk, m_valid, m_busy;
    logic [55:0] m_data;

    always #5 clk = ~clk;

    adc_serial_capture u_dut_a (
        .Main_CLK   (clk),
        .Reset      (rst_n),
        .Enable     (en_a),
        .Data_In    (din[0][1:0]),
        .CS         (cs_v[0]),
        .SCLK       (sclk_v[0]),
        .Data_Out   (dout_a),
        .Data_Valid (valid_v[0]),
        .Busy       (busy_v[0])
    );

    adc_serial_capture #(.CLK_DIV(2)) u_dut_b (
        .Main_CLK   (clk),
        .Reset      (rst_n),
        .Enable     (en_b),
        .Data_In    (din[1][1:0]),
        .CS         (cs_v[1]),
        .SCLK       (sclk_v[1]),
        .Data_Out   (dout_b),
        .Data_Valid (valid_v[1]),
        .Busy       (busy_v[1])
    );

    adc_serial_capture #(.NUM_CH(4), .DATA_W(14), .LEAD_BITS(0)) u_dut_c (
        .Main_CLK   (clk),
        .Reset      (rst_n),
        .Enable     (en_c),
        .Data_In    (din[2]),
        .CS         (cs_v[2]),
        .SCLK       (sclk_v[2]),
        .Data_Out   (dout_c),
        .Data_Valid (valid_v[2]),
        .Busy       (busy_v[2])
    );

    assign m_cs    = cs_v[sel];
    assign m_sclk  = sclk_v[sel];
    assign m_valid = valid_v[sel];
    assign m_busy  = busy_v[sel];
    assign m_data  = (sel == 0) ? {32'h0, dout_a} : (sel == 1) ? {32'h0, dout_b} : dout_c;

    // ADC model: latch a frame on CS fall, present the next bit MSB-first on each SCLK fall.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                frm[d] = 0;
                idx[d] = 0;
                din[d] = '0;
            end else if (pcs[d] && !cs_v[d]) begin
                for (int c = 0; c < 4; c++) strm[d][c] = pat[d][frm[d] % 4][c];
                frm[d] = frm[d] + 1;
                idx[d] = 0;
            end else if (!cs_v[d] && psclk[d] && !sclk_v[d] && idx[d] < 14) begin
                for (int c = 0; c < 4; c++) din[d][c] = strm[d][c][13 - idx[d]];
                idx[d] = idx[d] + 1;
            end
            pcs[d]   = cs_v[d];
            psclk[d] = sclk_v[d];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic set_pat(input int d, input int f, input logic [13:0] w0, input logic [13:0] w1,
                           input logic [13:0] w2, input logic [13:0] w3);
        pat[d][f][0] = w0;
        pat[d][f][1] = w1;
        pat[d][f][2] = w2;
        pat[d][f][3] = w3;
    endtask

    task automatic set_all(input int d, input logic [13:0] w0, input logic [13:0] w1,
                           input logic [13:0] w2, input logic [13:0] w3);
        for (int f = 0; f < 4; f++) set_pat(d, f, w0, w1, w2, w3);
    endtask

    // Counts negedges until Data_Valid is seen (-1 on timeout), with CS-low and SCLK-rise tallies.
    task automatic wait_valid(input int budget, output int cycles, output int cs_low,
                              output int rises, output logic [55:0] data);
        logic prev;
        cycles = 0;
        cs_low = 0;
        rises  = 0;
        data   = '0;
        prev   = m_sclk;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cycles++;
            if (!m_cs) cs_low++;
            if (!m_cs && m_sclk && !prev) rises++;
            prev = m_sclk;
            if (m_valid) begin
                data = m_data;
                return;
            end
        end
        cycles = -1;
    endtask

    task automatic wait_rises(input int n, output int seen);
        logic prev;
        seen = 0;
        prev = m_sclk;
        for (int i = 0; i < 200 && seen < n; i++) begin
            @(negedge clk);
            if (!m_cs && m_sclk && !prev) seen++;
            prev = m_sclk;
        end
    endtask

    initial begin
        int          cyc, csl, ris, bad, pulses;
        logic [55:0] dat;

        for (int d = 0; d < 3; d++) set_all(d, 14'h0, 14'h0, 14'h0, 14'h0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs",    64'(m_cs),    64'd1);
        check("rst_sclk",  64'(m_sclk),  64'd1);
        check("rst_data",  64'(m_data),  64'd0);
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_busy",  64'(m_busy),  64'd0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef ADC_CAPTURE_AVG_EN
        set_pat(0, 0, 14'h100, 14'hFFF, 14'h0, 14'h0);
        set_pat(0, 1, 14'h101, 14'hFFF, 14'h0, 14'h0);
        set_pat(0, 2, 14'h102, 14'hFFE, 14'h0, 14'h0);
        set_pat(0, 3, 14'h103, 14'hFFE, 14'h0, 14'h0);
        en_a = 1'b1;
        wait_valid(400, cyc, csl, ris, dat);
        check("avg_first_latency", 64'(cyc), 64'd141);
        check("avg_first_data",    64'(dat), 64'hFFE101);
        wait_valid(400, cyc, csl, ris, dat);
        check("avg_group_period",  64'(cyc), 64'd140);
        check("avg_second_data",   64'(dat), 64'hFFE101);
        set_all(0, 14'h00A, 14'h7FF, 14'h0, 14'h0);
        en_a = 1'b0;
        pulses = 0;
        repeat (100) begin
            @(negedge clk);
            if (m_valid) pulses++;
        end
        check("avg_partial_pulses", 64'(pulses), 64'd0);
        check("avg_idle_busy",      64'(m_busy), 64'd0);
        en_a = 1'b1;
        wait_valid(400, cyc, csl, ris, dat);
        check("avg_restart_latency", 64'(cyc), 64'd141);
        check("avg_restart_data",    64'(dat), 64'h7FF00A);
        en_a = 1'b0;
`else
        set_all(0, 14'hA5C, 14'h3F0, 14'h0, 14'h0);
        en_a = 1'b1;
        wait_valid(200, cyc, csl, ris, dat);
        check("a_first_latency", 64'(cyc), 64'd36);
        check("a_cs_low",        64'(csl), 64'd29);
        check("a_sclk_rises",    64'(ris), 64'd14);
        check("a_data",          64'(dat), 64'h3F0A5C);
        wait_valid(200, cyc, csl, ris, dat);
        check("a_period",        64'(cyc), 64'd35);
        check("a_cs_low_2",      64'(csl), 64'd29);
        check("a_data_2",        64'(dat), 64'h3F0A5C);
        set_all(0, 14'h001, 14'h800, 14'h0, 14'h0);
        @(negedge clk);
        check("a_valid_width",   64'(m_valid), 64'd0);
        wait_valid(200, cyc, csl, ris, dat);
        check("a_period_3",      64'(cyc), 64'd34);
        check("a_data_edges",    64'(dat), 64'h800001);
        repeat (10) @(negedge clk);
        check("a_data_hold",     64'(m_data), 64'h800001);

        // Enable dropped mid-frame
        set_all(0, 14'hFFF, 14'h000, 14'h0, 14'h0);
        wait_valid(200, cyc, csl, ris, dat);
        check("a_sync_data",     64'(dat), 64'h800001);
        wait_rises(5, ris);
        check("a_drop_sync",     64'(ris), 64'd5);
        en_a = 1'b0;
        wait_valid(200, cyc, csl, ris, dat);
        check("a_drop_data",     64'(dat), 64'h000FFF);
        bad    = 0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (m_valid) pulses++;
            if (!m_cs || !m_sclk || m_busy) bad++;
        end
        check("a_idle_pulses",   64'(pulses), 64'd0);
        check("a_idle_pins",     64'(bad),    64'd0);

        // Reset during SHIFT
        set_all(0, 14'h5A5, 14'hA5A, 14'h0, 14'h0);
        en_a = 1'b1;
        wait_rises(3, ris);
        check("a_rst_sync",      64'(ris), 64'd3);
        rst_n = 1'b0;
        #1;
        check("a_rst_cs",        64'(m_cs),    64'd1);
        check("a_rst_sclk",      64'(m_sclk),  64'd1);
        check("a_rst_data",      64'(m_data),  64'd0);
        check("a_rst_busy",      64'(m_busy),  64'd0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (m_valid) pulses++;
        end
        check("a_rst_pulses",    64'(pulses), 64'd0);
        rst_n = 1'b1;
        wait_valid(200, cyc, csl, ris, dat);
        check("a_restart_latency", 64'(cyc), 64'd36);
        check("a_restart_data",    64'(dat), 64'hA5A5A5);
        en_a = 1'b0;

        // CLK_DIV = 2
        set_all(1, 14'h0F0, 14'h00F, 14'h0, 14'h0);
        sel = 1;
        @(negedge clk);
        en_b = 1'b1;
        wait_valid(300, cyc, csl, ris, dat);
        check("b_first_latency", 64'(cyc), 64'd65);
        check("b_cs_low",        64'(csl), 64'd58);
        check("b_sclk_rises",    64'(ris), 64'd14);
        check("b_data",          64'(dat), 64'h00F0F0);
        wait_valid(300, cyc, csl, ris, dat);
        check("b_period",        64'(cyc), 64'd64);
        check("b_data_2",        64'(dat), 64'h00F0F0);
        en_b = 1'b0;

        // Four 14-bit lanes, no lead bits
        set_all(2, 14'h2ABC, 14'h1234, 14'h3FFF, 14'h0001);
        sel = 2;
        @(negedge clk);
        en_c = 1'b1;
        wait_valid(300, cyc, csl, ris, dat);
        check("c_first_latency", 64'(cyc), 64'd36);
        check("c_cs_low",        64'(csl), 64'd29);
        check("c_sclk_rises",    64'(ris), 64'd14);
        check("c_data",          64'(dat), 64'({14'h0001, 14'h3FFF, 14'h1234, 14'h2ABC}));
        wait_valid(300, cyc, csl, ris, dat);
        check("c_period",        64'(cyc), 64'd35);
        en_c = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
